data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: m0 = core load/store unit, m1 = debug/DMA port.
- Sits between the requesters and the RAM. Drives the RAM's ce/we/addr/sel/data_i and samples its combinational read data.
- Issues one access per cycle. Grant is combinational in the request cycle; read data returns registered one cycle later.
- Supports locked bursts, with a hold limit to stop one requester starving the other.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, width of the data word; sel is DATA_W/8 bits.
- MAX_HOLD, 8, maximum consecutive locked grants to one master while the other master is requesting (range 1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- m0_req  in  1  m0 access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  keep ownership after this access.
- m0_addr  in  ADDR_W  byte address.
- m0_sel  in  DATA_W/8  byte enables.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid.
- m0_rdata  out  DATA_W  read data.
- m1_*  same set as m0_*, for master 1.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_sel  out  DATA_W/8  RAM byte enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM combinational read data.
- owner  out  2  debug view of ownership: 00 none, 01 m0, 10 m1.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, owner=00, hold_cnt=0, last_gnt=1 (so m0 wins the first tie).
  - m0/m1_rvalid=0 and m0/m1_rdata=0.
  - Combinational outputs (gnt, ram_*) are forced to 0 while rst=0.
- Grant (combinational): at most one gnt per cycle.
  - When mN_gnt=1: ram_ce=1, and ram_we/addr/sel/wdata = mN's signals.
  - When no gnt: ram_ce=0, ram_we=0, and addr/sel/wdata=0.
- Write: commits at the clk edge that ends the grant cycle. No rvalid is produced for a write.
- Read: ram_rdata is captured at the grant-cycle edge. mN_rvalid=1 and mN_rdata=captured value in the following cycle, for exactly one cycle.
  - mN_rdata holds its last value until the next read completes.
  - Back-to-back reads give rvalid on consecutive cycles.
- States:
  - IDLE: no owner. Choose a winner by the arbitration policy (see Optional Feature).
    - If the winner has lock=1, go to OWNn with hold_cnt=1.
    - Otherwise stay in IDLE.
  - OWN0 / OWN1: only the owner can be granted, even when its req=0 (the other master waits).
    - When the owner is granted with lock=0, return to IDLE at that edge.
    - When the owner is granted with lock=1, increment hold_cnt, saturating at MAX_HOLD.
- Hold limit: in OWNn, if the other master has req=1 and hold_cnt==MAX_HOLD:
  - the owner's next grant is its last one in this ownership, regardless of lock;
  - the FSM then returns to IDLE and last_gnt=n, so the other master wins the next arbitration.
- Simultaneous requests in IDLE are resolved by the policy. The loser sees gnt=0 and must hold its request signals stable until granted.
- A requester may drop req without being granted. No state changes.
- Reset mid-burst: the FSM returns to IDLE and a pending rvalid is cancelled (rvalid=0 next cycle).
- Address bits below log2(DATA_W/8) pass through unchanged; word alignment is done by the RAM.

Optional Feature:
- Macro: DATA_RAM_ARB_RR_EN.
- Defined: round-robin in IDLE. On a tie, the master not equal to last_gnt wins. last_gnt updates on every grant.
- Undefined: fixed priority, m0 always wins ties in IDLE. last_gnt is used only by the hold-limit handoff. The hold-limit protection is still active.

Test Plan:
- Single read: preload word 0x10 = 0xDEADBEEF; m0 reads addr 0x10, sel=4'hF -> m0_gnt=1 in the same cycle with ram_ce=1, ram_we=0, ram_addr=0x10; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF.
- Byte write: m1 writes addr 0x20, sel=4'b0010, wdata=0x0000AB00 over a prior word of 0x11223344 -> a later read of 0x20 returns 0x1122AB44; m1_rvalid stays 0 during the write.
- Tie in IDLE: both masters request reads for 4 cycles.
  - With DATA_RAM_ARB_RR_EN: grants go m0, m1, m0, m1.
  - Without it: m0 is granted all 4 cycles; m1 is granted in cycle 5 after m0 drops req.
- Lock/hold limit with MAX_HOLD=3: m0 issues lock=1 writes continuously while m1 requests -> m0 gets 4 consecutive grants (hold_cnt reaches 3, plus the final grant), then m1 is granted; owner goes 01 -> 00 -> (m1).
- Owner idle in lock: m0 is granted with lock=1, then drops req for 2 cycles while m1 requests -> m1_gnt=0 in both cycles; m0 then accesses with lock=0 -> m1 is granted the following cycle.
- Reset mid-read: rst=0 in the cycle after an m0 read grant -> m0_rvalid=0, owner=00, no ram_ce until rst=1; after release, the first tie is granted to m0.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one single-port data RAM between the core LSU (m0)
// and the debug/DMA port (m1). One access per cycle, combinational grant,
// registered read data one cycle later. Locked bursts are bounded by a hold
// limit while the other master is waiting.
// Build option: DATA_RAM_ARB_RR_EN selects round-robin tie-breaking in IDLE;
// left undefined, m0 wins ties (except right after a hold-limit handoff).
module data_ram_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W/8-1:0]   m0_sel,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W/8-1:0]   m1_sel,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_sel,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [1:0]            owner
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic       last_gnt;   // 0 = m0 granted last, 1 = m1
  logic       tie_m1;     // m1 wins a simultaneous IDLE request
  logic       hold_max;
  logic       gnt0;
  logic       gnt1;

`ifndef DATA_RAM_ARB_RR_EN
  // Set when an ownership ended on the hold limit; lets the starved master
  // win the next tie even though m0 otherwise has fixed priority.
  logic       handoff;
`endif

  assign hold_max = (hold_cnt == HOLD_MAX);

  // Tie-break choice for IDLE arbitration
  always_comb begin
`ifdef DATA_RAM_ARB_RR_EN
    tie_m1 = ~last_gnt;
`else
    tie_m1 = handoff & ~last_gnt;
`endif
  end

  // Grant decision; nothing is granted while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (m0_req && m1_req) begin
            gnt1 = tie_m1;
            gnt0 = ~tie_m1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // RAM port mux: granted master's signals, all-zero when idle
  always_comb begin
    ram_ce    = gnt0 | gnt1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_sel   = m0_sel;
      ram_wdata = m0_wdata;
    end else if (gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_sel   = m1_sel;
      ram_wdata = m1_wdata;
    end
  end

  // Ownership FSM, hold counter, tie-break history and read-return registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 2'b00;
      hold_cnt  <= '0;
      last_gnt  <= 1'b1;
`ifndef DATA_RAM_ARB_RR_EN
      handoff   <= 1'b0;
`endif
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0 & ~m0_we;
      m1_rvalid <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) m0_rdata <= ram_rdata;
      if (gnt1 && !m1_we) m1_rdata <= ram_rdata;
`ifdef DATA_RAM_ARB_RR_EN
      if (gnt0 || gnt1) last_gnt <= gnt1;
`endif
      unique case (state)
        IDLE: begin
`ifndef DATA_RAM_ARB_RR_EN
          if (gnt0 || gnt1) handoff <= 1'b0;
`endif
          if (gnt0 && m0_lock) begin
            state    <= OWN0;
            owner    <= 2'b01;
            hold_cnt <= 8'd1;
          end else if (gnt1 && m1_lock) begin
            state    <= OWN1;
            owner    <= 2'b10;
            hold_cnt <= 8'd1;
          end
        end
        OWN0: begin
          if (gnt0) begin
            if (m1_req && hold_max) begin
              state    <= IDLE;
              owner    <= 2'b00;
              last_gnt <= 1'b0;
`ifndef DATA_RAM_ARB_RR_EN
              handoff  <= 1'b1;
`endif
            end else if (!m0_lock) begin
              state <= IDLE;
              owner <= 2'b00;
            end else if (!hold_max) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        OWN1: begin
          if (gnt1) begin
            if (m0_req && hold_max) begin
              state    <= IDLE;
              owner    <= 2'b00;
              last_gnt <= 1'b1;
`ifndef DATA_RAM_ARB_RR_EN
              handoff  <= 1'b1;
`endif
            end else if (!m1_lock) begin
              state <= IDLE;
              owner <= 2'b00;
            end else if (!hold_max) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          owner <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level arbitration model and a shadow memory.
module tb_data_ram_arbiter;

  localparam int MAXH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [1:0]  lock = '0;
  logic [31:0] addr [2];
  logic [3:0]  sel [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [1:0]  owner;

  logic [31:0] ram_mem [0:63];
  logic [31:0] ref_mem [0:63];

  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int want_g = -2;
  int last_g = -1;

  // reference model state: owner (-1 none), locked grant count, tie history
  int own = -1;
  int hold = 0;
  int last = 1;
  bit handoff = 1'b0;

  data_ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lock[0]), .m0_addr(addr[0]),
    .m0_sel(sel[0]), .m0_wdata(wdata[0]), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lock[1]), .m1_addr(addr[1]),
    .m1_sel(sel[1]), .m1_wdata(wdata[1]), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM behaviour: combinational read, byte-enabled write at the clock edge
  assign ram_rdata = ram_mem[ram_addr[7:2]];
  always @(posedge clk)
    if (ram_ce && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram_mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick();
    if (own >= 0) return req[own] ? own : -1;
    if (req[0] && req[1]) begin
`ifdef DATA_RAM_ARB_RR_EN
      return 1 - last;
`else
      return (handoff && last == 0) ? 1 : 0;
`endif
    end
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  // One cycle: inputs already set at the negedge; check, advance model, clock
  task automatic tick();
    int g;
    int idx;
    exp_t e;
    #1;
    g = pick();
    chk("owner", owner, own < 0 ? 0 : (own == 0 ? 1 : 2));
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    chk("ram_ce", ram_ce, g >= 0);
    if (want_g != -2) chk("directed_gnt", {m1_gnt, m0_gnt}, want_g < 0 ? 0 : (want_g == 0 ? 1 : 2));
    want_g = -2;
    if (g >= 0) begin
      chk("ram_we", ram_we, we[g]);
      chk("ram_addr", ram_addr, addr[g]);
      chk("ram_sel", ram_sel, sel[g]);
      chk("ram_wdata", ram_wdata, wdata[g]);
      idx = int'(addr[g][7:2]);
      if (!we[g]) begin
        e.d = ref_mem[idx];
        e.due = cyc + 1;
        if (g == 0) q0.push_back(e); else q1.push_back(e);
      end else begin
        for (int b = 0; b < 4; b++)
          if (sel[g][b]) ref_mem[idx][8*b +: 8] = wdata[g][8*b +: 8];
      end
      if (own < 0) begin
        handoff = 1'b0;
        if (lock[g]) begin own = g; hold = 1; end
      end else if (hold == MAXH && req[1-g]) begin
        own = -1; last = g; handoff = 1'b1;
      end else if (!lock[g]) begin
        own = -1;
      end else if (hold < MAXH) begin
        hold++;
      end
`ifdef DATA_RAM_ARB_RR_EN
      last = g;
`endif
    end else begin
      chk("ram_we_idle", ram_we, 0);
      chk("ram_addr_idle", ram_addr, 0);
      chk("ram_sel_idle", ram_sel, 0);
      chk("ram_wdata_idle", ram_wdata, 0);
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; holds reset for one edge with both masters requesting
  task automatic do_reset();
    rst = 1'b0;
    req = 2'b11;
    q0.delete();
    q1.delete();
    own = -1; hold = 0; last = 1; handoff = 1'b0; last_g = -1;
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_ram_ce", ram_ce, 0);
    chk("rst_ram_addr", ram_addr, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    rst = 1'b1;
    req = '0;
    lock = '0;
  endtask

  task automatic set_m(input int m, input bit r, input bit w, input bit l,
                       input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req[m] = r; we[m] = w; lock[m] = l; addr[m] = a; sel[m] = s; wdata[m] = d;
  endtask

  task automatic rand_m(input int m);
    set_m(m, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, 32'($urandom_range(0, 255)),
          4'($urandom_range(0, 15)), $urandom);
  endtask

  // Scoreboard monitor: pops expected read data whenever rvalid is shown
  task automatic mon(input int m, input logic rv, input logic [31:0] rd);
    exp_t e;
    int n;
    n = (m == 0) ? q0.size() : q1.size();
    if (rv) begin
      if (n == 0) begin
        chk(m == 0 ? "m0_rvalid_spurious" : "m1_rvalid_spurious", 1, 0);
      end else begin
        if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk(m == 0 ? "m0_rdata" : "m1_rdata", rd, e.d);
        chk(m == 0 ? "m0_rvalid_time" : "m1_rvalid_time", cyc, e.due);
      end
    end else if (n > 0) begin
      if (m == 0) e = q0[0]; else e = q1[0];
      if (e.due <= cyc) begin
        chk(m == 0 ? "m0_rvalid_missing" : "m1_rvalid_missing", 0, 1);
        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      mon(0, m0_rvalid, m0_rdata);
      mon(1, m1_rvalid, m1_rdata);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    ram_mem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    for (int m = 0; m < 2; m++) set_m(m, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    do_reset();

    // single read
    set_m(0, 1, 0, 0, 32'h10, 4'hF, 32'h0);
    want_g = 0; tick();
    chk("single_read_rvalid", m0_rvalid, 1);
    chk("single_read_rdata", m0_rdata, 32'hDEADBEEF);
    req = '0;

    // byte write then read back
    set_m(1, 1, 1, 0, 32'h20, 4'b0010, 32'h0000AB00);
    want_g = 1; tick();
    chk("byte_write_no_rvalid", m1_rvalid, 0);
    set_m(1, 1, 0, 0, 32'h20, 4'hF, 32'h0);
    tick();
    req = '0;
    chk("byte_write_readback", m1_rdata, 32'h1122AB44);

    // tie in IDLE for 4 cycles
    do_reset();
    set_m(0, 1, 0, 0, 32'h40, 4'hF, 32'h0);
    set_m(1, 1, 0, 0, 32'h44, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_RAM_ARB_RR_EN
      want_g = i % 2;
`else
      want_g = 0;
`endif
      tick();
    end
    req[0] = 1'b0;
    want_g = 1; tick();
    req = '0;

    // hold limit: m0 locked writes while m1 waits
    do_reset();
    set_m(0, 1, 1, 1, 32'h80, 4'hF, 32'hCAFE0001);
    set_m(1, 1, 0, 0, 32'h84, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      want_g = 0; tick();
      wdata[0] = wdata[0] + 1;
    end
    chk("hold_owner_released", owner, 0);
    want_g = 1; tick();
    req = '0;

    // owner idle while holding the lock
    do_reset();
    set_m(0, 1, 1, 1, 32'h90, 4'hF, 32'h12345678);
    want_g = 0; tick();
    req[0] = 1'b0;
    set_m(1, 1, 0, 0, 32'h94, 4'hF, 32'h0);
    want_g = -1; tick();
    want_g = -1; tick();
    set_m(0, 1, 0, 0, 32'h90, 4'hF, 32'h0);
    want_g = 0; tick();
    req[0] = 1'b0;
    want_g = 1; tick();
    req = '0;

    // reset in the cycle after a read grant, then first tie goes to m0
    set_m(0, 1, 0, 0, 32'h10, 4'hF, 32'h0);
    want_g = 0; tick();
    do_reset();
    set_m(0, 1, 0, 0, 32'h14, 4'hF, 32'h0);
    set_m(1, 1, 0, 0, 32'h18, 4'hF, 32'h0);
    want_g = 0; tick();
    req = '0;

    // randomized traffic; a master that lost holds its request stable
    for (int t = 0; t < 600; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (req[m] && last_g != m && own != m) begin
          if ($urandom_range(0, 9) == 0) req[m] = 1'b0;
        end else begin
          rand_m(m);
        end
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      else tick();
    end

    req = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
